// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type and S-box tables.
// The inverse table exists only when SUBBYTES_INV_EN is defined.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_BYTES   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sb_state_e;

    localparam logic [7:0] SBOX_FWD [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

`ifdef SUBBYTES_INV_EN
    localparam logic [7:0] SBOX_INV [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };
`endif

endpackage

// File: rtl/subbytes_iter_if.sv
// 128-bit AES state stream with valid/ready handshake.
interface subbytes_iter_if;
    import aes_pkg::*;

    logic                     valid;
    logic                     ready;
    logic [0:AES_BLOCK_W-1]   data;

    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/aes_sbox.sv
// Combinational AES S-box lookup; inverse select present when SUBBYTES_INV_EN is defined.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] data,
`ifdef SUBBYTES_INV_EN
    input  logic       inv,
`endif
    output logic [7:0] result
);

`ifdef SUBBYTES_INV_EN
    assign result = inv ? SBOX_INV[data] : SBOX_FWD[data];
`else
    assign result = SBOX_FWD[data];
`endif

endmodule

// File: rtl/subbytes_iter.sv
// Iterative AES SubBytes: one 4-byte column per cycle through four S-boxes.
// Optional SUBBYTES_INV_EN adds an inv port selecting the inverse S-box per block.
//
// state | meaning
// IDLE  | waiting for a block, in_ready=1
// BUSY  | substituting column col of st
// DONE  | st fully substituted, out_valid=1 until consumed
module subbytes_iter
    import aes_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
`ifdef SUBBYTES_INV_EN
    input  logic             inv,
`endif
    subbytes_iter_if.slave   up,
    subbytes_iter_if.master  dn
);

    sb_state_e               state_q, state_d;
    logic [1:0]              col_q, col_d;
    logic [0:AES_BLOCK_W-1]  st_q, st_d;
    logic [0:31]             col_word;
    logic [0:31]             sub_col;
    logic                    inv_sel;

`ifdef SUBBYTES_INV_EN
    logic                    inv_q, inv_d;
    assign inv_sel = inv_q;
`else
    assign inv_sel = 1'b0;
`endif

    always_comb begin
        col_word = '0;
        for (int c = 0; c < 4; c++) begin
            if (col_q == c[1:0]) col_word = st_q[32*c +: 32];
        end
    end

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .data   (col_word[8*b +: 8]),
`ifdef SUBBYTES_INV_EN
            .inv    (inv_sel),
`endif
            .result (sub_col[8*b +: 8])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= 2'd0;
            st_q    <= '0;
`ifdef SUBBYTES_INV_EN
            inv_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            st_q    <= st_d;
`ifdef SUBBYTES_INV_EN
            inv_q   <= inv_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        st_d      = st_q;
        up.ready  = 1'b0;
        dn.valid  = 1'b0;
`ifdef SUBBYTES_INV_EN
        inv_d     = inv_q;
`endif
        unique case (state_q)
            IDLE: begin
                up.ready = 1'b1;
                if (up.valid) begin
                    st_d    = up.data;
                    col_d   = 2'd0;
                    state_d = BUSY;
`ifdef SUBBYTES_INV_EN
                    inv_d   = inv;
`endif
                end
            end
            BUSY: begin
                for (int c = 0; c < 4; c++) begin
                    if (col_q == c[1:0]) st_d[32*c +: 32] = sub_col;
                end
                // col wraps back to 0 on the last column, ready for the next block
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) state_d = DONE;
            end
            DONE: begin
                dn.valid = 1'b1;
                up.ready = dn.ready;
                if (dn.ready) begin
                    if (up.valid) begin
                        st_d    = up.data;
                        col_d   = 2'd0;
                        state_d = BUSY;
`ifdef SUBBYTES_INV_EN
                        inv_d   = inv;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                col_d   = 2'd0;
            end
        endcase
    end

    assign dn.data = st_q;

endmodule

// File: tb/tb_subbytes_iter.sv
// Directed self-checking bench for subbytes_iter (FIPS-197 vectors, backpressure, reset, back-to-back).
module tb_subbytes_iter;
    import aes_pkg::*;

    logic clk;
    logic rst;
`ifdef SUBBYTES_INV_EN
    logic inv;
`endif

    subbytes_iter_if up_if ();
    subbytes_iter_if dn_if ();

    subbytes_iter dut (
        .clk (clk),
        .rst (rst),
`ifdef SUBBYTES_INV_EN
        .inv (inv),
`endif
        .up  (up_if.slave),
        .dn  (dn_if.master)
    );

    localparam logic [127:0] APPB_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] APPB_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] BYTE5_IN  = 128'h00000000_00530000_00000000_00000000;
    localparam logic [127:0] BYTE5_OUT = 128'h63636363_63ed6363_63636363_63636363;
    localparam logic [127:0] ALL_00 = {16{8'h00}};
    localparam logic [127:0] ALL_63 = {16{8'h63}};
    localparam logic [127:0] ALL_FF = {16{8'hff}};
    localparam logic [127:0] ALL_16 = {16{8'h16}};

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int in_xfers = 0;
    int out_xfers = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // inputs change 1 after posedge, so negedge sees the values the next edge will use
    always @(negedge clk) begin
        if (!rst && up_if.valid && up_if.ready) in_xfers <= in_xfers + 1;
        if (!rst && dn_if.valid && dn_if.ready) out_xfers <= out_xfers + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] d, input string tag);
        up_if.valid = 1'b1;
        up_if.data  = d;
        chk({tag, "_in_ready"}, 128'(up_if.ready), 128'd1);
        tick();
        up_if.valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!dn_if.valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic block(input logic [127:0] d, input logic [127:0] exp, input string tag);
        int lat;
        send(d, tag);
        wait_out(lat);
        chk({tag, "_latency"}, 128'(lat), 128'd4);
        chk({tag, "_data"}, dn_if.data, exp);
        tick();
    endtask

    initial begin
        int lat;
        int t_first;
        int t_second;
        int bad;
        int seen;
        int base;
        logic [127:0] snap;

        rst = 1'b1;
        up_if.valid = 1'b0;
        up_if.data  = '0;
        dn_if.ready = 1'b0;
`ifdef SUBBYTES_INV_EN
        inv = 1'b0;
`endif
        repeat (3) tick();
        chk("rst_out_valid", 128'(dn_if.valid), 128'd0);
        chk("rst_in_ready", 128'(up_if.ready), 128'd1);
        chk("rst_data_out", dn_if.data, 128'd0);
        rst = 1'b0;
        tick();

        dn_if.ready = 1'b1;
        block(APPB_IN, APPB_OUT, "appb");
        block(BYTE5_IN, BYTE5_OUT, "byte5");

        // asynchronous reset in the middle of BUSY at col=2
        base = out_xfers;
        send(APPB_IN, "midrst");
        tick();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 128'(dn_if.valid), 128'd0);
        chk("midrst_in_ready", 128'(up_if.ready), 128'd1);
        chk("midrst_data_out", dn_if.data, 128'd0);
        tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (dn_if.valid) seen++;
        end
        chk("midrst_no_output", 128'(seen), 128'd0);
        chk("midrst_no_xfer", 128'(out_xfers - base), 128'd0);

        // backpressure: hold the output for 10 cycles while offering a new block
        dn_if.ready = 1'b0;
        send(BYTE5_IN, "bp");
        wait_out(lat);
        chk("bp_latency", 128'(lat), 128'd4);
        chk("bp_data", dn_if.data, BYTE5_OUT);
        snap = dn_if.data;
        base = in_xfers;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            up_if.valid = 1'b1;
            up_if.data  = ALL_FF;
            tick();
            if (dn_if.data !== snap || up_if.ready !== 1'b0 || dn_if.valid !== 1'b1) bad++;
        end
        chk("bp_hold_violations", 128'(bad), 128'd0);
        chk("bp_no_accept", 128'(in_xfers - base), 128'd0);
        up_if.valid = 1'b0;
        base = out_xfers;
        dn_if.ready = 1'b1;
        tick();
        dn_if.ready = 1'b0;
        repeat (6) tick();
        chk("bp_one_xfer", 128'(out_xfers - base), 128'd1);
        chk("bp_idle_out_valid", 128'(dn_if.valid), 128'd0);
        chk("bp_idle_in_ready", 128'(up_if.ready), 128'd1);

        // back-to-back with in_valid and out_ready held high
        base = out_xfers;
        dn_if.ready = 1'b1;
        up_if.valid = 1'b1;
        up_if.data  = ALL_00;
        tick();
        up_if.data  = ALL_FF;
        wait_out(lat);
        t_first = cyc;
        chk("b2b_first_latency", 128'(lat), 128'd4);
        chk("b2b_first_data", dn_if.data, ALL_63);
        chk("b2b_in_ready_done", 128'(up_if.ready), 128'd1);
        tick();
        up_if.valid = 1'b0;
        chk("b2b_valid_drops", 128'(dn_if.valid), 128'd0);
        wait_out(lat);
        t_second = cyc;
        chk("b2b_second_data", dn_if.data, ALL_16);
        chk("b2b_spacing", 128'(t_second - t_first), 128'd5);
        tick();
        tick();
        chk("b2b_xfers", 128'(out_xfers - base), 128'd2);

`ifdef SUBBYTES_INV_EN
        inv = 1'b1;
        block(ALL_63, ALL_00, "inv63");
        block(APPB_OUT, APPB_IN, "inv_appb");
        inv = 1'b0;
        block(APPB_IN, APPB_OUT, "fwd_after_inv");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
